rot_step_decoder: RTL



---
 rtl/rot_pkg.sv | 22 ++
 rtl/rot_left_comb.sv | 21 ++
 rtl/rot_step_decoder.sv | 140 ++++++++++++++
 3 files changed

// File: rtl/rot_pkg.sv
// Shared types and helpers for the LED rotate-left stepper and its decoder.
package rot_pkg;

    localparam int ROT_WIDTH = 8;
    localparam int ROT_AMT_W = $clog2(ROT_WIDTH);

    // Plain encoded constants keep the state bits visible to older tools.
    typedef logic [1:0] state_t;
    localparam state_t IDLE   = 2'd0;
    localparam state_t SEARCH = 2'd1;
    localparam state_t DONE   = 2'd2;

    function automatic logic [ROT_WIDTH-1:0] rotl(
        input logic [ROT_WIDTH-1:0] x,
        input logic [ROT_AMT_W-1:0] k
    );
        logic [ROT_AMT_W:0] rs;
        rs = (ROT_AMT_W+1)'(ROT_WIDTH) - {1'b0, k};
        return (x << k) | (x >> rs);
    endfunction

endpackage

// File: rtl/rot_left_comb.sv
// Combinational left rotator, shared by the stepper and the decoder.
module rot_left_comb
    import rot_pkg::*;
#(
    parameter int WIDTH = ROT_WIDTH,
    parameter int AMT_W = $clog2(WIDTH)
) (
    input  logic [WIDTH-1:0] x,
    input  logic [AMT_W-1:0] k,
    output logic [WIDTH-1:0] y
);

    localparam logic [AMT_W:0] W_L = (AMT_W+1)'(WIDTH);

    // For k = 0 the right shift is by WIDTH and contributes nothing.
    logic [AMT_W:0] rs;

    assign rs = W_L - {1'b0, k};
    assign y  = (x << k) | (x >> rs);

endmodule

// File: rtl/rot_step_decoder.sv
// Recovers the left-rotation step between consecutive stepper samples.
// Define ROT_DECODE_AMBIG_EN for a full search and the out_ambig flag.
module rot_step_decoder
    import rot_pkg::*;
#(
    parameter int WIDTH = ROT_WIDTH,
    parameter int AMT_W = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    output logic             in_ready,
    output logic             out_valid,
    output logic [AMT_W-1:0] out_amount,
    output logic             out_match
`ifdef ROT_DECODE_AMBIG_EN
    ,
    output logic             out_ambig
`endif
);

    localparam logic [AMT_W-1:0] K_LAST = AMT_W'(WIDTH - 1);

    state_t           state;
    logic             have_prev;
    logic [WIDTH-1:0] prev;
    logic [WIDTH-1:0] cur;
    logic [WIDTH-1:0] rot;
    logic [AMT_W-1:0] k;
    logic             hit;
    logic             last;

    logic             res_done;
    logic             res_match;
    logic [AMT_W-1:0] res_amount;

    rot_left_comb #(
        .WIDTH(WIDTH),
        .AMT_W(AMT_W)
    ) u_rot (
        .x(prev),
        .k(k),
        .y(rot)
    );

    assign hit      = (rot == cur);
    assign last     = (k == K_LAST);
    assign in_ready = (state == IDLE);

`ifdef ROT_DECODE_AMBIG_EN
    logic             found;
    logic             multi;
    logic [AMT_W-1:0] first_k;
    logic             res_ambig;

    // Fold the current step into the running result so the last step counts.
    assign res_done   = last;
    assign res_match  = found | hit;
    assign res_amount = found ? first_k : (hit ? k : '0);
    assign res_ambig  = multi | (found & hit);
`else
    assign res_done   = hit | last;
    assign res_match  = hit;
    assign res_amount = hit ? k : '0;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            have_prev  <= 1'b0;
            prev       <= '0;
            cur        <= '0;
            k          <= '0;
            out_valid  <= 1'b0;
            out_amount <= '0;
            out_match  <= 1'b0;
`ifdef ROT_DECODE_AMBIG_EN
            out_ambig  <= 1'b0;
            found      <= 1'b0;
            multi      <= 1'b0;
            first_k    <= '0;
`endif
        end else if (clear) begin
            state     <= IDLE;
            have_prev <= 1'b0;
            out_valid <= 1'b0;
        end else begin
            out_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        if (!have_prev) begin
                            prev      <= in_data;
                            have_prev <= 1'b1;
                        end else begin
                            cur   <= in_data;
                            k     <= '0;
                            state <= SEARCH;
`ifdef ROT_DECODE_AMBIG_EN
                            found <= 1'b0;
                            multi <= 1'b0;
`endif
                        end
                    end
                end
                SEARCH: begin
`ifdef ROT_DECODE_AMBIG_EN
                    if (hit) begin
                        if (!found) begin
                            found   <= 1'b1;
                            first_k <= k;
                        end else begin
                            multi <= 1'b1;
                        end
                    end
`endif
                    if (res_done) begin
                        out_valid  <= 1'b1;
                        out_amount <= res_amount;
                        out_match  <= res_match;
`ifdef ROT_DECODE_AMBIG_EN
                        out_ambig  <= res_ambig;
`endif
                        state      <= DONE;
                    end else begin
                        k <= k + 1'b1;
                    end
                end
                DONE: begin
                    prev  <= cur;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
